fnd_scan_driver: RTL and testbench
==================================

# fnd_scan_driver

Multiplexed driver for the 8-digit common-row seven-segment (FND) display. It consumes the eight 4-bit digit values produced by the cascaded BCD counter chain and scans them onto the shared segment bus and one-hot row select. Frames are tear-free, each slot has an anti-ghosting blank interval, and leading-zero blanking is optional. It sits directly downstream of the counters and replaces ad-hoc row/segment logic in the top level.

## Interface
- SCAN_DIV, 1024: clocks per digit slot; legal range 2..65536.
- BLANK_CYCLES, 16: dead clocks at the start of each slot with row and segments forced off; legal range 1..SCAN_DIV-1.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- digits  input  32  digit i on [4i+3:4i]; digit 0 is least significant; values 0..15.
- dp_mask  input  8  bit i lights the decimal point of digit i.
- lz_blank  input  1  1 = blank leading zeros.
- enable  input  1  0 = force fnd_row and seg to zero; scanning continues.
- seg  output  8  {A,B,C,D,E,F,G,DP}, bit 7 = A, 1 = lit.
- fnd_row  output  8  one-hot row select, bit i = digit i, 1 = active.
- frame_tick  output  1  one-clock pulse at end of each 8-slot frame.

## Operation
- State: prescaler p (0..SCAN_DIV-1), slot index i (0..7), snapshot registers snap_digits[31:0] and snap_dp[7:0]. All outputs are registered.
- Counting: p increments every clock. At p==SCAN_DIV-1, p wraps to 0 and i increments; i wraps 7→0.
- Snapshot: on any edge where the pre-edge state is p==0 and i==0, load digits and dp_mask into the snapshot registers. Inputs are ignored at all other times, so the displayed frame is always coherent.
- Row output at each edge is computed from the pre-edge state:
  - fnd_row = onehot(i) when p >= BLANK_CYCLES and enable == 1.
  - Otherwise fnd_row = 0.
- Segment output at each edge: if the row is forced off, seg = 0. Otherwise seg = {decode(d), dp}, where d is snapshot digit i and dp is snap_dp[i].
- Decode {A..G}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero blanking: when lz_blank == 1, digit i (i >= 1) is blank if snapshot digits i..7 are all zero.
  - A blank digit drives {A..G}=0 but still drives its DP bit and its row.
  - Digit 0 is never blanked.
  - lz_blank is sampled live, not snapshotted.
- frame_tick = 1 for exactly the one clock after the edge whose pre-edge state is p==SCAN_DIV-1 and i==7; 0 otherwise.

## Timing
- Reset (async assert): p=0, i=0, snap_digits=0, snap_dp=0, seg=0x00, fnd_row=0x00, frame_tick=0.
- Count edges from the first rising edge after rst deasserts as edge 1. Pre-edge state at edge c is p=(c-1) mod SCAN_DIV and i=((c-1) div SCAN_DIV) mod 8.
- The first snapshot is taken at edge 1. Slot 0 of the first frame shows digits as sampled at edge 1; the first B edges of that slot are blanked, so no stale data is visible.
- For SCAN_DIV=N and BLANK_CYCLES=B, the row for slot k is active after edges k*N+B+1 .. (k+1)*N within a frame. Frame period is 8N clocks; frame_tick is high after edge 8N, 16N, and so on.
- Latency from a digits change to display is up to 8N+B+1 clocks, worst case when the change arrives just after a snapshot.
- enable takes effect one clock after it is sampled, with no effect on p, i or snapshots.
- rst mid-frame: outputs go to zero immediately (asynchronous). The scan restarts from slot 0 with a new snapshot at the first post-release edge.
- fnd_row is never multi-hot, and rows of consecutive slots never overlap, because B >= 1.

## Test plan
- Bench uses SCAN_DIV=8, BLANK_CYCLES=2 throughout.
- Reset/release:
  - Stimulus: hold rst, then release with digits=0x76543210, dp_mask=0, enable=1, lz_blank=0.
  - Response: outputs 0 after edges 1–2; after edges 3..8, fnd_row=0x01 and seg=0xFC; after edges 11..16, fnd_row=0x02 and seg=0x60; after edges 9–10, all zero.
- Frame tick and wrap:
  - Stimulus: run 3 frames.
  - Response: frame_tick high only after edges 64, 128, 192; slot 7 (fnd_row=0x80, seg=0xE0) precedes slot 0 at each wrap.
- Snapshot coherence:
  - Stimulus: change digits to 0x99999999 at edge 20 (mid-frame).
  - Response: remaining slots of frame 1 still show old digits; from edge 67, slot 0 shows seg=0xF6.
- Leading-zero blanking:
  - Stimulus: digits=0x00012345, dp_mask=0x20, lz_blank=1.
  - Response: slot 4 seg=0x60; slot 5 seg=0x01 with fnd_row=0x20; slots 6–7 seg=0x00 with rows still one-hot; all-zero digits shows only digit 0 as 0xFC.
- Hex and DP:
  - Stimulus: digits=0xFEDCBA98, dp_mask=0xFF.
  - Response, slots 0..7 seg: 0xFF, 0xF7, 0xEF, 0x3F, 0x9D, 0x7B, 0x9F, 0x8F.
- Enable and async reset:
  - Stimulus: drop enable at edge 30.
  - Response: seg and fnd_row are 0 from edge 31; on re-enable, the scan position is unchanged.
  - Stimulus: assert rst between edges.
  - Response: all outputs 0 before the next edge.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
// Multiplexed scan driver for an 8-digit common-row seven-segment display.
// Each digit gets one slot of SCAN_DIV clocks. The first BLANK_CYCLES clocks
// of every slot are dark, so the segment bus can settle between rows and no
// ghosting appears. Digit values and decimal points are captured once per
// frame, at the start of slot 0, which keeps every frame tear-free.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   digits     eight 4-bit digit values, digit i on [4i+3:4i], digit 0 = LSD
//   dp_mask    bit i lights the decimal point of digit i
//   lz_blank   1 = blank leading zeros (sampled live)
//   enable     0 = force fnd_row/seg off; scanning keeps running
//   seg        {A,B,C,D,E,F,G,DP}, 1 = lit
//   fnd_row    one-hot row select, bit i = digit i
//   frame_tick one-clock pulse after the last clock of each 8-slot frame
module fnd_scan_driver #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_mask,
    input  logic        lz_blank,
    input  logic        enable,
    output logic [7:0]  seg,
    output logic [7:0]  fnd_row,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // The slot timer counts down from CNT_TOP to zero. A count of CNT_TOP
    // means "first clock of the slot"; counts at or below CNT_LIT are past
    // the blank interval.
    localparam logic [CW-1:0] CNT_TOP = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LIT = CW'(SCAN_DIV - 1 - BLANK_CYCLES);

    logic [CW-1:0] slot_cnt;
    logic [2:0]    slot;
    logic [31:0]   snap_digits;
    logic [7:0]    snap_dp;

    logic          slot_end;
    logic          frame_start;
    logic          row_on;
    logic [3:0]    cur_digit;
    logic [7:0]    lead_zero;
    logic          digit_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign slot_end    = (slot_cnt == '0);
    assign frame_start = (slot_cnt == CNT_TOP) && (slot == 3'd0);
    assign row_on      = enable && (slot_cnt <= CNT_LIT);
    assign cur_digit   = snap_digits[{slot, 2'b00} +: 4];

    // lead_zero[k]: snapshot digits k..7 are all zero.
    always_comb begin
        lead_zero = '0;
        for (int k = 0; k < 8; k++) begin
            lead_zero[k] = ((snap_digits >> (4 * k)) == 32'd0);
        end
    end

    // Digit 0 always shows, so an all-zero value still reads "0".
    assign digit_blank = lz_blank && (slot != 3'd0) && lead_zero[slot];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt    <= CNT_TOP;
            slot        <= 3'd0;
            snap_digits <= '0;
            snap_dp     <= '0;
            seg         <= '0;
            fnd_row     <= '0;
            frame_tick  <= 1'b0;
        end else begin
            if (slot_end) begin
                slot_cnt <= CNT_TOP;
                slot     <= slot + 3'd1;
            end else begin
                slot_cnt <= slot_cnt - 1'b1;
            end

            if (frame_start) begin
                snap_digits <= digits;
                snap_dp     <= dp_mask;
            end

            if (row_on) begin
                fnd_row <= 8'(1) << slot;
                seg     <= {digit_blank ? 7'b0000000 : seg_decode(cur_digit),
                            snap_dp[slot]};
            end else begin
                fnd_row <= '0;
                seg     <= '0;
            end

            frame_tick <= slot_end && (slot == 3'd7);
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2).
// A reference model derives each clock's expected outputs from the global
// edge count and queues them; a monitor pops and compares on the falling edge.
module tb_fnd_scan_driver;

    localparam int N = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits = 32'h0;
    logic [7:0]  dp_mask = 8'h0;
    logic        lz_blank = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  seg;
    logic [7:0]  fnd_row;
    logic        frame_tick;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ticks_seen = 0;

    logic [6:0] seg_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    fnd_scan_driver #(.SCAN_DIV(N), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .enable     (enable),
        .seg        (seg),
        .fnd_row    (fnd_row),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: mc = number of edges since reset release, so the
    // pre-edge position is p = mc mod N, slot = (mc div N) mod 8.
    int unsigned mc = 0;
    logic [31:0] m_digits = 32'h0;
    logic [7:0]  m_dp = 8'h0;

    always @(posedge clk) begin : model
        exp_t       e;
        int         p;
        int         s;
        logic [3:0] d;
        logic       blank;
        e = '0;
        if (rst) begin
            mc = 0;
            m_digits = 32'h0;
            m_dp = 8'h0;
        end else begin
            p = int'(mc % N);
            s = int'((mc / N) % 8);
            if (p >= B && enable) begin
                e.row = 8'(1 << s);
                d = m_digits[4*s +: 4];
                blank = lz_blank && (s >= 1) && ((m_digits >> (4 * s)) == 32'd0);
                e.seg = {blank ? 7'b0 : seg_tbl[d], m_dp[s]};
            end
            e.tick = (p == N - 1) && (s == 7);
            if (p == 0 && s == 0) begin
                m_digits = digits;
                m_dp = dp_mask;
            end
            mc++;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({fnd_row, seg, frame_tick} !== e) begin
                errors++;
                $display("FAIL scan t=%0t: got row=%h seg=%h tick=%b, want row=%h seg=%h tick=%b",
                         $time, fnd_row, seg, frame_tick, e.row, e.seg, e.tick);
            end
            if (frame_tick === 1'b1) ticks_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rnd_step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 39) == 0) digits = $urandom >> (4 * $urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) dp_mask = 8'($urandom);
            if ($urandom_range(0, 29) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 24) == 0) enable = ~enable;
        end
    endtask

    initial begin
        digits = 32'h76543210;
        dp_mask = 8'h00;
        lz_blank = 1'b0;
        enable = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {23'd0, fnd_row, seg, frame_tick}, 32'd0);
        rst = 1'b0;
        ticks_seen = 0;

        // Change digits mid-frame; the running frame must keep old values.
        step(19);
        digits = 32'h99999999;
        step(48);
        @(negedge clk);
        #1;
        check("slot0_new_snapshot", {16'd0, fnd_row, seg}, 32'h000001F6);
        step(125);
        @(negedge clk);
        #1;
        check("three_frame_ticks", 32'(ticks_seen), 32'd3);

        // Leading-zero blanking, then all zeros.
        digits = 32'h00012345;
        dp_mask = 8'h20;
        lz_blank = 1'b1;
        step(16 * N);
        digits = 32'h00000000;
        dp_mask = 8'h00;
        step(16 * N);

        // Hex digits with all decimal points.
        digits = 32'hFEDCBA98;
        dp_mask = 8'hFF;
        lz_blank = 1'b0;
        step(16 * N);

        // Enable drop keeps outputs dark.
        enable = 1'b0;
        step(3);
        check("disabled_dark", {16'd0, fnd_row, seg}, 32'd0);
        enable = 1'b1;
        step(20);

        rnd_step(1500);

        // Asynchronous reset while a row is lit.
        enable = 1'b1;
        for (int w = 0; w < 40 && fnd_row == 8'h00; w++) @(negedge clk);
        check("row_lit_before_rst", {31'd0, fnd_row != 8'h00}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {23'd0, fnd_row, seg, frame_tick}, 32'd0);
        step(2);
        digits = $urandom;
        dp_mask = 8'($urandom);
        rst = 1'b0;
        rnd_step(24 * N);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
